// File: rtl/spi_pkg.sv
// Shared types and limits for the SPI main controller.
package spi_pkg;

  localparam int unsigned SPI_MIN_CLK_DIV = 4;
  localparam int unsigned SPI_MIN_CS_IDLE = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } spi_main_state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; phase_done pulses for one cycle when a loaded count reaches zero.
module spi_phase_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_phase_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_phase_done = r_run && (r_cnt == '0);

endmodule

// File: rtl/spi_main.sv
// SPI mode-0 initiator, MSB first, one word per chip-select assertion.
// Define SPI_MAIN_LOOPBACK_EN to sample out_bit instead of in_bit.
module spi_main
  import spi_pkg::*;
#(
  parameter int unsigned WORD_BITS = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_IDLE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sck,
  output logic                 out_bit,
  input  logic                 in_bit,
  output logic                 cs,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid
);

  localparam int unsigned TMAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam int unsigned BW   = $clog2(WORD_BITS) + 1;

  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_bad_clk_div
    $error("spi_main: CLK_DIV below minimum");
  end
  if (CS_IDLE < SPI_MIN_CS_IDLE) begin : g_bad_cs_idle
    $error("spi_main: CS_IDLE below minimum");
  end
  if (WORD_BITS < 2) begin : g_bad_word_bits
    $error("spi_main: WORD_BITS below 2");
  end

  spi_main_state_t      r_state, w_state_d;
  logic                 w_load;
  logic [TW-1:0]        w_load_val;
  logic                 w_phase_done;
  logic                 w_sample;
  logic [WORD_BITS-1:0] r_tx_shift, r_rx_shift, r_rx_data;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_cs, r_sck, r_out_bit, r_rx_valid;

`ifdef SPI_MAIN_LOOPBACK_EN
  assign w_sample = r_out_bit;
`else
  assign w_sample = in_bit;
`endif

  spi_phase_timer #(
    .CNT_W (TW)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_val   (w_load_val),
    .o_phase_done (w_phase_done)
  );

  always_comb begin
    w_state_d  = r_state;
    w_load     = 1'b0;
    w_load_val = TW'(CLK_DIV - 1);
    case (r_state)
      StIdle: if (tx_valid) begin
        w_state_d = StSetup;
        w_load    = 1'b1;
      end
      StSetup, StLow: if (w_phase_done) begin
        w_state_d = StHigh;
        w_load    = 1'b1;
      end
      StHigh: if (w_phase_done) begin
        w_state_d = (r_bit_cnt == '0) ? StHold : StLow;
        w_load    = 1'b1;
      end
      StHold: if (w_phase_done) begin
        w_state_d  = StGap;
        w_load     = 1'b1;
        w_load_val = TW'(CS_IDLE - 1);
      end
      StGap: if (w_phase_done) begin
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Pin values are registered from the next state so they change on the state edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cs       <= 1'b1;
      r_sck      <= 1'b0;
      r_out_bit  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cs       <= !(w_state_d inside {StSetup, StHigh, StLow, StHold});
      r_sck      <= (w_state_d == StHigh);
      r_rx_valid <= (r_state == StHold) && w_phase_done;
      if (r_state == StIdle && tx_valid) begin
        r_tx_shift <= tx_data;
        r_out_bit  <= tx_data[WORD_BITS-1];
        r_bit_cnt  <= BW'(WORD_BITS - 1);
      end
      if (r_state == StHigh && w_phase_done && r_bit_cnt != '0) begin
        r_tx_shift <= r_tx_shift << 1;
        r_out_bit  <= r_tx_shift[WORD_BITS-2];
        r_bit_cnt  <= r_bit_cnt - 1'b1;
      end
      // Sample in the last cycle before each rising sck edge.
      if ((r_state == StSetup || r_state == StLow) && w_phase_done) begin
        r_rx_shift <= {r_rx_shift[WORD_BITS-2:0], w_sample};
      end
      if (r_state == StHold && w_phase_done) begin
        r_rx_data <= r_rx_shift;
      end
    end
  end

  assign tx_ready = (r_state == StIdle);
  assign sck      = r_sck;
  assign cs       = r_cs;
  assign out_bit  = r_out_bit;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_main.sv
// Randomized bench for spi_main with a cycle-level reference model and a behavioural secondary.
module tb_spi_main;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned G  = 4;
  localparam int          N  = D * (2 * W + 1);
  localparam int unsigned W2 = 16;
  localparam int unsigned D2 = 6;
`ifdef SPI_MAIN_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sck, out_bit, in_bit, cs, tx_valid, tx_ready, rx_valid;
  logic [W-1:0] tx_data, rx_data;

  logic          rst2 = 1'b1;
  logic          sck2, out_bit2, cs2, tx_valid2, tx_ready2, rx_valid2;
  logic [W2-1:0] tx_data2, rx_data2;

  spi_main #(.WORD_BITS(W), .CLK_DIV(D), .CS_IDLE(G)) dut (
    .clk(clk), .rst(rst), .sck(sck), .out_bit(out_bit), .in_bit(in_bit), .cs(cs),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  // Second instance wired MOSI->MISO externally, so it must receive its own word.
  spi_main #(.WORD_BITS(W2), .CLK_DIV(D2), .CS_IDLE(G)) dut2 (
    .clk(clk), .rst(rst2), .sck(sck2), .out_bit(out_bit2), .in_bit(out_bit2), .cs(cs2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: everything follows from the accept edge t_acc and cycle offset k.
  int           cyc   = 0;
  int           t_acc = -1;
  int           k_old;
  bit           m_rst = 1'b0;
  logic [W-1:0] m_word = '0, m_sec = '0, m_rx = '0;
  logic [W-1:0] s_next = '0;

  always @(posedge clk) begin
    k_old = cyc - t_acc;
    cyc++;
    if (rst) begin
      t_acc = -1;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (tx_valid && (t_acc < 0 || k_old >= N + G)) begin
        t_acc  = cyc;
        m_word = tx_data;
        m_sec  = s_next;
      end
    end
  end

  int k, p, idx, rxv_cnt = 0, hi_run = 0, min_gap = 1000;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxv_cnt++;
    if (cs === 1'b1) hi_run++;
    else if (hi_run > 0) begin
      if (hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
    if (m_rst) begin
      m_rx = '0;
      check("rst_cs", cs, 1);
      check("rst_sck", sck, 0);
      check("rst_mosi", out_bit, 0);
      check("rst_rxv", rx_valid, 0);
      check("rst_rxd", rx_data, 0);
      check("rst_rdy", tx_ready, 1);
    end else if (cyc > 0) begin
      k = (t_acc < 0) ? 100000 : cyc - t_acc;
      if (k == N) m_rx = LB ? m_word : m_sec;
      check("cs", cs, (k < N) ? 0 : 1);
      check("sck", sck, (k < N && ((k / D) % 2) == 1) ? 1 : 0);
      check("rxv", rx_valid, (k == N) ? 1 : 0);
      check("rdy", tx_ready, (k >= N + G) ? 1 : 0);
      check("rxd", rx_data, m_rx);
      if (k < N) begin
        p   = k / D;
        idx = (p / 2 >= W) ? 0 : W - 1 - p / 2;
        check("mosi", out_bit, m_word[idx]);
      end
    end
  end

  // Behavioural secondary: reload on cs fall, shift out on sck fall, capture on sck rise.
  logic [W-1:0] s_shift = '0, s_rx = '0;
  int           s_rises = 0;
  logic         p_cs = 1'b1, p_sck = 1'b0;
  assign in_bit = s_shift[W-1];

  always @(cs or sck) begin
    if (p_cs === 1'b1 && cs === 1'b0) begin
      s_shift = s_next;
      s_rx    = '0;
      s_rises = 0;
    end else if (cs === 1'b0 && p_sck === 1'b0 && sck === 1'b1) begin
      s_rx = {s_rx[W-2:0], out_bit};
      s_rises++;
    end else if (cs === 1'b0 && p_sck === 1'b1 && sck === 1'b0) begin
      s_shift = s_shift << 1;
    end
    if (p_cs === 1'b0 && cs === 1'b1 && rst === 1'b0) begin
      check("sec_rises", s_rises, W);
      check("sec_word", s_rx, m_word);
    end
    p_cs  = cs;
    p_sck = sck;
  end

  int acc_q[$];
  always @(posedge clk) if (!rst && tx_valid && tx_ready) acc_q.push_back(int'($time / 10));

  task automatic send(input logic [W-1:0] w, input logic [W-1:0] sw);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", (n < 300) ? 1 : 0, 1);
    tx_data  = w;
    s_next   = sw;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rxv(output int lat, output int lo);
    lat = 0;
    lo  = 0;
    while (rx_valid !== 1'b1 && lat < 400) begin
      if (cs === 1'b0) lo++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Wide instance: one directed word.
  logic [W2-1:0] m2 = '0;
  int            rises2 = 0;
  bit            done2 = 1'b0;
  always @(posedge sck2) begin
    m2 = {m2[W2-2:0], out_bit2};
    rises2++;
  end

  initial begin
    int n;
    tx_valid2 = 1'b0;
    tx_data2  = '0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    tx_data2  = 16'h8001;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    check("d2_msb", out_bit2, 1);
    check("d2_cs", cs2, 0);
    n = 0;
    while (rx_valid2 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    // rx_valid sampled at edge T+1+6*33 = T+199, i.e. 198 cycles after the accept cycle.
    check("d2_lat", n, 198);
    check("d2_rxd", rx_data2, 16'h8001);
    check("d2_mosi", m2, 16'h8001);
    check("d2_rises", rises2, 16);
    done2 = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lo, rxv0, n;
    logic [W-1:0] rw, rs;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    check("lit_rst_cs", cs, 1);
    check("lit_rst_rxd", rx_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("lit_rdy_after_rst", tx_ready, 1);

    // Secondary returns 0x3C while 0xC3 goes out.
    send(8'hC3, 8'h3C);
    wait_rxv(lat, lo);
    check("lit_rxv_lat", lat, 68);
    check("lit_cs_low", lo, 68);
    check("lit_rxd_c3", rx_data, LB ? 8'hC3 : 8'h3C);
    check("lit_sec_c3", s_rx, 8'hC3);
    check("lit_rises", s_rises, 8);

    // tx_valid with 0xFF mid-word must be ignored.
    send(8'h00, 8'h96);
    repeat (20) @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_rxv(lat, lo);
    check("lit_rxd_00", rx_data, LB ? 8'h00 : 8'h96);
    check("lit_sec_00", s_rx, 8'h00);

    // Back-to-back words with tx_valid held high and data churning every cycle.
    while (tx_ready !== 1'b1) @(negedge clk);
    acc_q.delete();
    tx_valid = 1'b1;
    for (int i = 0; i < 3 * 73 + 2; i++) begin
      tx_data = W'($urandom);
      s_next  = W'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("lit_acc_cnt", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++) check("lit_acc_gap", acc_q[i] - acc_q[i-1], 73);

    // Reset during the bit-3 high phase.
    send(8'h77, 8'h11);
    repeat (37) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("lit_mid_cs", cs, 1);
    check("lit_mid_sck", sck, 0);
    check("lit_mid_rxv", rx_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("lit_mid_rdy", tx_ready, 1);
    rxv0 = rxv_cnt;
    repeat (80) @(negedge clk);
    check("lit_mid_no_rxv", rxv_cnt - rxv0, 0);
    send(8'h5A, 8'hA5);
    wait_rxv(lat, lo);
    check("lit_rxd_5a", rx_data, LB ? 8'h5A : 8'hA5);
    check("lit_sec_5a", s_rx, 8'h5A);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      rw = W'($urandom);
      rs = W'($urandom);
      send(rw, rs);
    end
    repeat (100) @(negedge clk);
    check("lit_min_gap", (min_gap >= 4) ? 1 : 0, 1);

    n = 0;
    while (!done2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("d2_done", done2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
